uart_rx: RTL
============

Name: uart_rx

Overview:
UART serial receiver, 8N1 framing, LSB first. It is the receive-side counterpart of the team's uart_tx and shares its CLKS_PER_BIT timing. The block sits between the FPGA RX pin, fed by the Bluetooth/serial module, and the car command decoder. It presents each received byte with a one-cycle valid strobe and flags framing errors.

Parameters:
CLKS_PER_BIT, 87, system clocks per UART bit; must be at least 4.
HALF_BIT, (CLKS_PER_BIT-1)/2 (integer division), clock count at which the start bit is re-checked; 43 at the default.

Ports:
i_Clock  input  1  system clock; all logic is on the rising edge.
i_Rst_n  input  1  asynchronous active-low reset.
i_Rx_Serial  input  1  raw serial line; idles high; asynchronous to i_Clock.
o_Rx_DV  output  1  one-cycle strobe; o_Rx_Byte is valid in that cycle.
o_Rx_Byte  output  8  last good byte; changes only together with o_Rx_DV.
o_Rx_Active  output  1  high while a frame is being received.
o_Frame_Err  output  1  one-cycle strobe when the stop bit samples low.

Behaviour:
- Reset (i_Rst_n low, asynchronous): state IDLE, counters 0, o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Frame_Err=0, both synchroniser flops=1.
- i_Rx_Serial passes through a 2-flop synchroniser; rx_s is the second flop. All decisions use rx_s (2-cycle input latency).
- Single clock counter clk_cnt, width $clog2(CLKS_PER_BIT); bit_idx is 3 bits.
- IDLE: clk_cnt=0, bit_idx=0. rx_s==0 -> START and o_Rx_Active=1.
- START: count up. At clk_cnt==HALF_BIT:
  - rx_s==0 -> clk_cnt=0, go to DATA.
  - rx_s==1 -> glitch; go to IDLE with o_Rx_Active=0, no strobes.
- DATA: count up. At clk_cnt==CLKS_PER_BIT-1 (one full bit after the previous sample point, i.e. mid-bit):
  - shift register bit bit_idx <= rx_s, clk_cnt=0.
  - bit_idx<7 -> increment bit_idx, stay in DATA.
  - bit_idx==7 -> bit_idx=0, go to STOP.
- STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s:
  - rx_s==1: o_Rx_Byte<=shift register and o_Rx_DV=1 for exactly one cycle.
  - rx_s==0: o_Frame_Err=1 for one cycle; o_Rx_Byte unchanged; no DV.
  - Either way: o_Rx_Active=0, go to CLEANUP.
- CLEANUP: wait until rx_s==1, then go to IDLE. This handles line-break and stuck-low without re-triggering. A good frame normally spends 1 cycle here.
- o_Rx_DV and o_Frame_Err are never high together. Both are registered outputs.
- Latency: o_Rx_DV rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 2 clocks (±1) after the falling edge of the start bit: 830 ±2 at the default.
- Back-to-back frames: a start bit arriving immediately after the stop bit's sample point must be accepted, so no idle gap is required beyond the stop bit.
- Reset asserted mid-frame aborts it immediately with no strobe. After release, wait for rx_s==0 from IDLE. A partial frame in progress is treated as a new start and will typically end in a framing error or glitch rejection.
- Unused state encodings go to IDLE.

Optional Feature:
UART_RX_PARITY_EN
- Defined: adds a PARITY state between DATA and STOP, sampled at CLKS_PER_BIT-1.
  - New parameter PARITY_ODD, default 0 (even parity).
  - New output o_Parity_Err, 1 bit, reset 0.
  - Parity mismatch: pulse o_Parity_Err in the stop-sample cycle, suppress o_Rx_DV, leave o_Rx_Byte unchanged.
  - If the stop bit is also low, both o_Parity_Err and o_Frame_Err pulse.
  - Frame is 11 bits; latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no o_Parity_Err port, behaviour exactly as above (8N1).

Test Plan:
- Reset low for 5 clocks, then drive 0xA5 at 87 clk/bit with a good stop bit -> single o_Rx_DV pulse at 830 ±2 clocks after the start edge, o_Rx_Byte=8'hA5, o_Frame_Err never high.
- 0x00 followed immediately by 0xFF, no idle gap -> two DV pulses 870 ±2 clocks apart, bytes 8'h00 then 8'hFF.
- 20-clock low glitch on an idle line -> no o_Rx_DV, o_Rx_Active drops within 45 clocks, o_Rx_Byte holds its previous value.
- 0x3C with stop bit driven low, line held low for 300 clocks, then 0x5A -> one o_Frame_Err pulse, o_Rx_Byte stays at its old value, no spurious frame during the low hold, then DV with 8'h5A.
- i_Rst_n pulsed low during data bit 4 of a frame -> outputs return to reset values asynchronously, no DV for the aborted frame; a clean 0x81 sent afterwards is received correctly.
- (UART_RX_PARITY_EN, even) 0x07 with parity bit=1 -> DV with 8'h07; same byte with parity bit=0 -> o_Parity_Err pulse, no DV.

Source files
------------

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Serial input and receive-side result signals of uart_rx.
//               o_Parity_Err exists only when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Active;
    logic       o_Frame_Err;
`ifdef UART_RX_PARITY_EN
    logic       o_Parity_Err;
`endif

    // Receiver side: consumes the line, produces the byte and status strobes.
    modport master (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Active,
        output o_Frame_Err
`ifdef UART_RX_PARITY_EN
        ,
        output o_Parity_Err
`endif
    );

    modport slave (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Rx_Active,
        input  o_Frame_Err
`ifdef UART_RX_PARITY_EN
        ,
        input  o_Parity_Err
`endif
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first, mid-bit sampling with a
//               one-cycle byte strobe and framing-error strobe.
//               Define UART_RX_PARITY_EN to add a parity bit (8x1 framing).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  wire logic  i_Clock,
    input  wire logic  i_Rst_n,
    uart_rx_if.master  rx
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(HALF_BIT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY  = 3'd5
`endif
    } state_t;

    state_t               r_state, w_state;
    logic                 r_rx_meta, r_rx_s;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt;
    logic [2:0]           r_idx, w_idx;
    logic [7:0]           r_shift, w_shift;
    logic [7:0]           r_byte, w_byte;
    logic                 r_dv, w_dv;
    logic                 r_active, w_active;
    logic                 r_ferr, w_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 r_par, w_par;
    logic                 r_perr, w_perr;
    logic                 w_par_bad;

    assign w_par_bad = (^r_shift) ^ r_par ^ PARITY_ODD;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
            r_byte    <= 8'h00;
            r_dv      <= 1'b0;
            r_active  <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_rx_meta <= rx.i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_shift   <= w_shift;
            r_byte    <= w_byte;
            r_dv      <= w_dv;
            r_active  <= w_active;
            r_ferr    <= w_ferr;
`ifdef UART_RX_PARITY_EN
            r_par     <= w_par;
            r_perr    <= w_perr;
`endif
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_idx    = r_idx;
        w_shift  = r_shift;
        w_byte   = r_byte;
        w_dv     = 1'b0;
        w_active = r_active;
        w_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par    = r_par;
        w_perr   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                w_idx = 3'd0;
                if (!r_rx_s) begin
                    w_state  = S_START;
                    w_active = 1'b1;
                end
            end
            S_START: begin
                // Re-check the start bit near its centre to reject short glitches.
                if (r_cnt == c_HALF) begin
                    w_cnt = '0;
                    if (!r_rx_s) begin
                        w_state = S_DATA;
                    end else begin
                        w_state  = S_IDLE;
                        w_active = 1'b0;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_LAST) begin
                    w_cnt          = '0;
                    w_shift[r_idx] = r_rx_s;
                    if (r_idx == 3'd7) begin
                        w_idx   = 3'd0;
`ifdef UART_RX_PARITY_EN
                        w_state = S_PARITY;
`else
                        w_state = S_STOP;
`endif
                    end else begin
                        w_idx = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == c_LAST) begin
                    w_cnt   = '0;
                    w_par   = r_rx_s;
                    w_state = S_STOP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == c_LAST) begin
                    w_cnt    = '0;
                    w_active = 1'b0;
                    w_state  = S_CLEANUP;
                    w_ferr   = ~r_rx_s;
`ifdef UART_RX_PARITY_EN
                    w_perr   = w_par_bad;
                    if (r_rx_s && !w_par_bad) begin
`else
                    if (r_rx_s) begin
`endif
                        w_dv   = 1'b1;
                        w_byte = r_shift;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_CLEANUP: begin
                // Holding here until the line is high keeps a break from re-triggering.
                if (r_rx_s) begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state  = S_IDLE;
                w_cnt    = '0;
                w_idx    = 3'd0;
                w_active = 1'b0;
            end
        endcase
    end

    assign rx.o_Rx_DV      = r_dv;
    assign rx.o_Rx_Byte    = r_byte;
    assign rx.o_Rx_Active  = r_active;
    assign rx.o_Frame_Err  = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign rx.o_Parity_Err = r_perr;
`endif

endmodule
`default_nettype wire
